amp_i2c_master: RTL and testbench
=================================

# amp_i2c_master

I2C bus master that issues single-register write and read transactions to the MA12070 amplifier's control port (amp_i2c_scl / amp_i2c_sda). It sits in the toi2s top level beside the existing I2C slave and register bank, and drives the amplifier side of the board, which the slave cannot reach. The top level owns the open-drain pads: an SDA output of 0 pulls the pad low; an output of 1 releases it to high-Z.

## Interface
Parameters:
- CLK_DIV, 68, clk cycles per quarter SCL bit (about 100 kHz SCL at 27 MHz); legal range 2..1023
- DEV_ADDR, 7'h20, 7-bit amplifier device address

Ports:
- clk  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- start  in  1  request a transaction; sampled only in IDLE
- rw  in  1  0 = write, 1 = read
- reg_addr  in  8  amplifier register address
- wdata  in  8  write data
- rdata  out  8  read data, valid from the `done` pulse until the next read completes
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- ack_err  out  1  last transaction saw a NACK; valid from `done`
- scl_out  out  1  0 = pull SCL low, 1 = release
- scl_in  in  1  SCL pad readback (used only with stretching)
- sda_out  out  1  0 = pull SDA low, 1 = release
- sda_in  in  1  SDA pad readback

## Operation
- States: IDLE, START, TXBYTE, RXACK, RSTART, RXBYTE, MNACK, STOP, DONE.
- Every state is made of bit slots. A bit slot is 4 phases (ph0..ph3), each CLK_DIV cycles long.
- Phase counter width is ceil(log2(CLK_DIV)) bits. Bit counter runs 7 down to 0, MSB first.
- TXBYTE bit slot:
  - SDA changes at ph0 entry.
  - SCL is low in ph0–ph1 and released in ph2–ph3.
- RXACK and RXBYTE:
  - SDA is released.
  - sda_in is sampled on the last cycle of ph2.
- START:
  - ph0–ph1: SCL and SDA both released.
  - ph2–ph3: SDA low, SCL released.
- RSTART: same as START, except SCL is low in ph0.
- STOP:
  - ph0: SCL low, SDA low.
  - ph1–ph2: SCL released, SDA low.
  - ph3: both released.
- MNACK: master drives SDA released (NACK) for one bit slot.
- Write sequence: START, {DEV_ADDR,0}, RXACK, reg_addr, RXACK, wdata, RXACK, STOP, DONE.
- Read sequence: START, {DEV_ADDR,0}, RXACK, reg_addr, RXACK, RSTART, {DEV_ADDR,1}, RXACK, RXBYTE, MNACK, STOP, DONE.
- NACK (sampled 1) in any RXACK:
  - ack_err is set and the FSM goes directly to STOP.
  - rdata keeps its old value.
- IDLE with start=1:
  - rw, reg_addr and wdata are captured into internal registers.
  - ack_err is cleared and the FSM enters START.
- start while busy=1 is ignored; it is not queued.
- No arbitration-loss detection; this block is the only master on the amplifier bus.

## Timing
- Reset values: scl_out=1, sda_out=1, busy=0, done=0, ack_err=0, rdata=8'h00, state IDLE.
- busy rises the cycle after start is accepted.
- DONE lasts one cycle: done=1 and busy=0 in that same cycle, then the FSM returns to IDLE.
- A new start is accepted in the first IDLE cycle after DONE.
- Latency from start to done, successful transaction:
  - write: 116·CLK_DIV+2 cycles
  - read: 156·CLK_DIV+2 cycles
- Latency with a NACK on the first address byte: 44·CLK_DIV+2 cycles.
- Reset asserted mid-transaction: both lines are released immediately (asynchronously) and the FSM goes to IDLE. No STOP is generated.

## Configuration
- Macro: AMP_I2C_MASTER_STRETCH_EN.
- Defined:
  - In ph2 of any slot, the phase counter holds while scl_out=1 and scl_in=0 (slave clock stretching).
  - Counting resumes the cycle after scl_in reads 1.
  - A stretch adds exactly its length to the latency.
- Undefined: scl_in is ignored and timing is fixed as given under Timing.

## Test plan
Bench uses CLK_DIV=4, DEV_ADDR=7'h20, and a slave model with a pull-up.
- Write reg 0x35 = 0xA5, slave ACKs:
  - bytes on the bus are 0x40, 0x35, 0xA5, followed by STOP
  - done arrives 466 cycles after start
  - ack_err=0
- Read reg 0x35, slave returns 0x5C:
  - bytes on the bus are 0x40, 0x35, RSTART, 0x41, then 0x5C with a master NACK, then STOP
  - rdata=0x5C
  - done arrives 626 cycles after start
- Slave NACKs the address byte:
  - STOP follows immediately
  - ack_err=1 and done arrive 178 cycles after start
  - rdata is unchanged
- Second start pulse at cycle 50 of a write: ignored; exactly one transaction on the bus and one done pulse.
- resetb pulsed low mid-data-byte:
  - scl_out=1 and sda_out=1 within the same cycle
  - busy=0
  - next start runs a clean write
- With AMP_I2C_MASTER_STRETCH_EN defined, slave holds SCL low for 20 cycles during the data ACK: done is delayed by exactly 20 cycles versus the unstretched write.

Source files
------------

// File: rtl/amp_i2c_master.sv
// amp_i2c_master: single-register write/read I2C master for the MA12070 amplifier control port.
// Optional slave clock stretching is enabled by defining AMP_I2C_MASTER_STRETCH_EN.
module amp_i2c_master #(
  parameter int         CLK_DIV  = 68,
  parameter logic [6:0] DEV_ADDR = 7'h20
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_out,
  input  logic       scl_in,
  output logic       sda_out,
  input  logic       sda_in
);
  // state  | meaning
  // IDLE   | bus released, waiting for start
  // START  | one lead-in cycle, then the start-condition slot
  // TXBYTE | shift a byte out, MSB first
  // RXACK  | release SDA and sample the slave ACK
  // RSTART | repeated start ahead of the read address
  // RXBYTE | shift the read byte in, MSB first
  // MNACK  | master NACK closing the read
  // STOP   | stop condition
  // DONE   | one-cycle completion pulse
  typedef enum logic [3:0] {
    IDLE, START, TXBYTE, RXACK, RSTART, RXBYTE, MNACK, STOP, DONE
  } state_t;

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [1:0]    ph_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitc_q;
  logic [1:0]    byte_q;
  logic          lead_q;
  logic          rw_q;
  logic [7:0]    reg_q, wd_q, txb_q, rxb_q;
  logic          nack_q;
  logic          on_bus, stall, ph_end, slot_end, sample, accept;

  assign on_bus = (state_q != IDLE) && (state_q != DONE);
  assign accept = (state_q == IDLE) && start;

`ifdef AMP_I2C_MASTER_STRETCH_EN
  // A slave holding SCL low during ph2 freezes the phase counter.
  assign stall = lead_q | ((ph_q == 2'd2) && scl_out && !scl_in);
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall         = lead_q;
`endif

  assign ph_end   = on_bus && !stall && (cnt_q == '0);
  assign slot_end = ph_end && (ph_q == 2'd3);
  assign sample   = ph_end && (ph_q == 2'd2);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    scl_out = 1'b1;
    sda_out = 1'b1;
    busy    = on_bus;
    done    = (state_q == DONE);
    case (state_q)
      IDLE:   if (start) state_d = START;
      START: begin
        sda_out = ~ph_q[1];
        if (slot_end) state_d = TXBYTE;
      end
      TXBYTE: begin
        scl_out = ph_q[1];
        sda_out = txb_q[bitc_q];
        if (slot_end && (bitc_q == 3'd0)) state_d = RXACK;
      end
      RXACK: begin
        scl_out = ph_q[1];
        if (slot_end) begin
          if (nack_q)              state_d = STOP;
          else if (byte_q == 2'd0) state_d = TXBYTE;
          else if (byte_q == 2'd1) state_d = rw_q ? RSTART : TXBYTE;
          else                     state_d = rw_q ? RXBYTE : STOP;
        end
      end
      RSTART: begin
        scl_out = (ph_q != 2'd0);
        sda_out = ~ph_q[1];
        if (slot_end) state_d = TXBYTE;
      end
      RXBYTE: begin
        scl_out = ph_q[1];
        if (slot_end && (bitc_q == 3'd0)) state_d = MNACK;
      end
      MNACK: begin
        scl_out = ph_q[1];
        if (slot_end) state_d = STOP;
      end
      STOP: begin
        scl_out = (ph_q != 2'd0);
        sda_out = (ph_q == 2'd3);
        if (slot_end) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ph_q    <= 2'd0;
      cnt_q   <= CNT_MAX;
      bitc_q  <= 3'd7;
      byte_q  <= 2'd0;
      lead_q  <= 1'b0;
      rw_q    <= 1'b0;
      reg_q   <= 8'h00;
      wd_q    <= 8'h00;
      txb_q   <= 8'h00;
      rxb_q   <= 8'h00;
      nack_q  <= 1'b0;
      rdata   <= 8'h00;
      ack_err <= 1'b0;
    end else if (accept) begin
      rw_q    <= rw;
      reg_q   <= reg_addr;
      wd_q    <= wdata;
      ack_err <= 1'b0;
      lead_q  <= 1'b1;
      ph_q    <= 2'd0;
      cnt_q   <= CNT_MAX;
    end else begin
      lead_q <= 1'b0;
      if (ph_end) begin
        cnt_q <= CNT_MAX;
        ph_q  <= ph_q + 2'd1;
      end else if (on_bus && !stall) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (sample && (state_q == RXACK))  nack_q <= sda_in;
      if (sample && (state_q == RXBYTE)) rxb_q  <= {rxb_q[6:0], sda_in};
      if (slot_end) begin
        case (state_q)
          START: begin
            txb_q  <= {DEV_ADDR, 1'b0};
            bitc_q <= 3'd7;
            byte_q <= 2'd0;
          end
          TXBYTE: bitc_q <= bitc_q - 3'd1;
          RXACK: begin
            bitc_q <= 3'd7;
            if (nack_q) begin
              ack_err <= 1'b1;
            end else if (byte_q == 2'd0) begin
              txb_q  <= reg_q;
              byte_q <= 2'd1;
            end else if (byte_q == 2'd1) begin
              txb_q  <= wd_q;
              byte_q <= 2'd2;
            end
          end
          RSTART: begin
            txb_q  <= {DEV_ADDR, 1'b1};
            bitc_q <= 3'd7;
            byte_q <= 2'd2;
          end
          RXBYTE: begin
            bitc_q <= bitc_q - 3'd1;
            if (bitc_q == 3'd0) rdata <= rxb_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amp_i2c_master.sv
// Testbench for amp_i2c_master: open-drain bus with a pull-up and an I2C slave model; expected
// bus tokens and completion results are queued at issue time and checked by a negedge monitor.
module tb_amp_i2c_master;
  localparam int         CD  = 4;
  localparam logic [6:0] DEV = 7'h20;
  localparam int T_START = 1;
  localparam int T_STOP  = 2;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, ack_err, scl_out, sda_out;
  logic       scl_in, sda_in;
  logic       slave_sda = 1'b1;
  logic       hold_scl;

  amp_i2c_master #(.CLK_DIV(CD), .DEV_ADDR(DEV)) dut (
    .clk(clk), .resetb(resetb), .start(start), .rw(rw), .reg_addr(reg_addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
    .scl_out(scl_out), .scl_in(scl_in), .sda_out(sda_out), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  assign sda_in = sda_out & slave_sda;
  assign scl_in = scl_out & ~hold_scl;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef AMP_I2C_MASTER_STRETCH_EN
  int rise_n = 0, rise_base = 0, hold_n = 0;
  bit stretch_arm = 1'b0;
  always @(posedge scl_out) if (stretch_arm) rise_n++;
  assign hold_scl = stretch_arm && ((rise_n - rise_base) == 27) && (hold_n < 20);
  always @(posedge clk) if (hold_scl) hold_n <= hold_n + 1;
`else
  assign hold_scl = 1'b0;
`endif

  typedef struct {
    logic       aerr;
    logic [7:0] rd;
    int         k;
    int         lat;
  } done_exp_t;

  int        exp_bus[$];
  done_exp_t exp_done[$];
  int        checks = 0, errors = 0, n_done = 0;
  logic [7:0] model_rdata = 8'h00;
  bit        nack_addr = 1'b0, ignore_bus = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic int tok(input logic [7:0] b, input logic a);
    return 1024 + (a ? 256 : 0) + int'(b);
  endfunction

  // Slave model plus scoreboard monitor
  logic       p_scl = 1'b1, p_sda = 1'b1, cs, ds, first = 1'b0, reading = 1'b0;
  int         bit_i = 0;
  logic [7:0] sh = 8'h00;
  done_exp_t  de;

  task automatic bus_token(input int v);
    if (exp_bus.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL bus_extra: actual token %0h required none", v);
    end else begin
      check("bus_token", v, exp_bus.pop_front());
    end
  endtask

  always @(negedge clk) begin
    cs = scl_in;
    ds = sda_in;
    if (done === 1'b1) begin
      n_done++;
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: actual done=1 required no pulse");
      end else begin
        de = exp_done.pop_front();
        check("ack_err", ack_err, de.aerr);
        check("rdata", rdata, de.rd);
        check("latency", cyc - de.k, de.lat);
        check("busy_at_done", busy, 0);
      end
    end
    if (ignore_bus) begin
      bit_i = 0; reading = 1'b0; first = 1'b0; slave_sda = 1'b1;
    end else if (p_scl && cs && p_sda && !ds) begin
      bus_token(T_START);
      bit_i = 0; first = 1'b1; reading = 1'b0; slave_sda = 1'b1;
    end else if (p_scl && cs && !p_sda && ds) begin
      bus_token(T_STOP);
      bit_i = 0; reading = 1'b0; slave_sda = 1'b1;
    end else if (!p_scl && cs) begin
      if (bit_i < 8) begin
        sh = {sh[6:0], ds};
        bit_i++;
      end else if (bit_i == 8) begin
        bus_token(tok(sh, ds));
        bit_i = 9;
      end
    end else if (p_scl && !cs) begin
      if (bit_i == 8) begin
        slave_sda = (reading || (first && nack_addr)) ? 1'b1 : 1'b0;
      end else if (bit_i == 9) begin
        bit_i = 0;
        if (first && sh[0] && !nack_addr && !reading) begin
          reading = 1'b1;
          slave_sda = rd_byte[7];
        end else begin
          reading = 1'b0;
          slave_sda = 1'b1;
        end
        first = 1'b0;
      end else if (reading && bit_i >= 1 && bit_i <= 7) begin
        slave_sda = rd_byte[7 - bit_i];
      end
    end
    p_scl = cs;
    p_sda = ds;
  end

  // Reference model: bus tokens and completion from the transaction rules
  task automatic issue(input logic r, input logic [7:0] ra, input logic [7:0] wd,
                       input logic nk, input logic [7:0] rb, input int extra);
    int slots;
    done_exp_t e;
    nack_addr = nk;
    rd_byte = rb;
    exp_bus.push_back(T_START);
    exp_bus.push_back(tok({DEV, 1'b0}, nk));
    if (nk) begin
      slots = 1 + 9 + 1;
    end else begin
      exp_bus.push_back(tok(ra, 1'b0));
      if (!r) begin
        exp_bus.push_back(tok(wd, 1'b0));
        slots = 1 + 3 * 9 + 1;
      end else begin
        exp_bus.push_back(T_START);
        exp_bus.push_back(tok({DEV, 1'b1}, 1'b0));
        exp_bus.push_back(tok(rb, 1'b1));
        slots = 1 + 2 * 9 + 1 + 9 + 9 + 1;
        model_rdata = rb;
      end
    end
    exp_bus.push_back(T_STOP);
    e.aerr = nk;
    e.rd   = model_rdata;
    e.lat  = slots * 4 * CD + 2 + extra;
    @(negedge clk);
    start = 1'b1; rw = r; reg_addr = ra; wdata = wd;
    e.k = cyc;
    exp_done.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (n_done == prev && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", (n_done != prev), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic r, input logic [7:0] ra, input logic [7:0] wd,
                     input logic nk, input logic [7:0] rb, input int extra);
    int prev;
    prev = n_done;
    issue(r, ra, wd, nk, rb, extra);
    wait_done(prev);
  endtask

  initial begin
    int prev;
    repeat (3) @(negedge clk);
    check("rst_scl", scl_out, 1);
    check("rst_sda", sda_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rdata", rdata, 8'h00);
    resetb = 1'b1;
    repeat (2) @(negedge clk);

    run(1'b0, 8'h35, 8'hA5, 1'b0, 8'h00, 0);
    run(1'b1, 8'h35, 8'h00, 1'b0, 8'h5C, 0);
    run(1'b0, 8'h10, 8'h33, 1'b1, 8'h00, 0);

    // second start while busy must be dropped
    prev = n_done;
    issue(1'b0, 8'h12, 8'h3C, 1'b0, 8'h00, 0);
    repeat (48) @(negedge clk);
    check("busy_mid", busy, 1);
    start = 1'b1; rw = 1'b1; reg_addr = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    wait_done(prev);
    repeat (700) @(negedge clk);
    check("single_done", n_done - prev, 1);
    check("bus_drained", exp_bus.size(), 0);

    // reset in the middle of the data byte
    issue(1'b0, 8'h77, 8'h0F, 1'b0, 8'h00, 0);
    repeat (355) @(negedge clk);
    check("busy_pre_rst", busy, 1);
    ignore_bus = 1'b1;
    resetb = 1'b0;
    #1;
    check("arst_scl", scl_out, 1);
    check("arst_sda", sda_out, 1);
    check("arst_busy", busy, 0);
    @(negedge clk);
    exp_bus.delete();
    exp_done.delete();
    model_rdata = 8'h00;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_rdata", rdata, 8'h00);
    ignore_bus = 1'b0;
    repeat (2) @(negedge clk);
    run(1'b0, 8'h77, 8'h0F, 1'b0, 8'h00, 0);

    for (int i = 0; i < 8; i++) begin
      logic r, nk;
      logic [7:0] ra, wd, rb;
      r  = 1'($urandom_range(0, 1));
      nk = ($urandom_range(0, 3) == 0);
      ra = 8'($urandom);
      wd = 8'($urandom);
      rb = 8'($urandom);
      run(r, ra, wd, nk, rb, 0);
    end

`ifdef AMP_I2C_MASTER_STRETCH_EN
    rise_base = rise_n;
    stretch_arm = 1'b1;
    run(1'b0, 8'h35, 8'hA5, 1'b0, 8'h00, 20);
    stretch_arm = 1'b0;
`endif

    check("exp_bus_empty", exp_bus.size(), 0);
    check("exp_done_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: actual time limit reached required completion");
    $fatal(1, "watchdog");
  end
endmodule
